// File: rtl/apb3_completer_fifo_pkg.sv
`default_nettype none
// ============================================================================
// apb3_completer_fifo_pkg : register offsets, bit positions and state types
// Revision : 1.0
// ============================================================================
package apb3_completer_fifo_pkg;

    localparam int unsigned DataOffset   = 32'h0;
    localparam int unsigned StatusOffset = 32'h4;
    localparam int unsigned CtrlOffset   = 32'h8;

    localparam int unsigned StatusCountLsb    = 0;
    localparam int unsigned StatusEmptyBit    = 16;
    localparam int unsigned StatusFullBit     = 17;
    localparam int unsigned StatusOverflowBit = 24;

    localparam int unsigned CtrlFlushBit  = 0;
    localparam int unsigned CtrlClrOvfBit = 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } fifo_state_e;

    typedef enum logic [1:0] {
        AccData   = 2'd0,
        AccStatus = 2'd1,
        AccCtrl   = 2'd2,
        AccNone   = 2'd3
    } acc_kind_e;

    function automatic logic [31:0] status_word(input logic [15:0] count,
                                                input logic        empty,
                                                input logic        full,
                                                input logic        ovf);
        logic [31:0] w;
        w = '0;
        w[StatusCountLsb +: 16]  = count;
        w[StatusEmptyBit]        = empty;
        w[StatusFullBit]         = full;
        w[StatusOverflowBit]     = ovf;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb3_completer_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo_showahead : single-clock show-ahead FIFO with flush
// Revision : 1.0
// ============================================================================
module sync_fifo_showahead #(
    parameter  int unsigned Depth = 8,
    parameter  int unsigned Width = 32,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [Width-1:0] data_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             w_push;
    logic             w_pop;

    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            // Flush dominates any pop presented on the same edge
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CntW'(w_push) - CntW'(w_pop);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb3_completer_fifo.sv
`default_nettype none
// ============================================================================
// apb3_completer_fifo : APB3 completer pushing DATA writes into a stream FIFO
// Optional macro APB3_COMPLETER_FIFO_PSLVERR_EN enables pslverr responses.
// Revision : 1.0
// ============================================================================
module apb3_completer_fifo
    import apb3_completer_fifo_pkg::*;
#(
    parameter int unsigned AddressWidth  = 20,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned Depth         = 8,
    parameter int unsigned MaxWaitCycles = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AddressWidth-1:0] paddr,
    input  logic                    pwrite,
    input  logic                    psel,
    input  logic                    penable,
    input  logic [DataWidth-1:0]    pwdata,
    output logic [DataWidth-1:0]    prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DataWidth-1:0]    out_data
);

    localparam int unsigned CntW  = $clog2(Depth) + 1;
    localparam int unsigned WaitW = (MaxWaitCycles > 1) ? $clog2(MaxWaitCycles + 1) : 1;

    fifo_state_e          state_q, state_d;
    acc_kind_e            kind_q, kind_d;
    acc_kind_e            w_kind;
    logic                 write_q, write_d;
    logic                 timeout_q, timeout_d;
    logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
    logic                 pready_q, pready_d;
    logic [DataWidth-1:0] prdata_q, prdata_d;
    logic                 overflow_q, overflow_d;

    logic [CntW-1:0]      w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_resp_edge;
    logic                 w_push;
    logic                 w_flush;
    logic                 w_ctrl_wr;

    always_comb begin
        w_kind = AccNone;
        if (paddr == AddressWidth'(DataOffset))        w_kind = AccData;
        else if (paddr == AddressWidth'(StatusOffset)) w_kind = AccStatus;
        else if (paddr == AddressWidth'(CtrlOffset))   w_kind = AccCtrl;
    end

    // Side effects are tied to the completing edge of the transfer
    assign w_resp_edge = psel & penable & pready_q;
    assign w_ctrl_wr   = w_resp_edge & (kind_q == AccCtrl) & write_q;
    assign w_push      = w_resp_edge & (kind_q == AccData) & write_q & ~timeout_q;
    assign w_flush     = w_ctrl_wr & pwdata[CtrlFlushBit];

    always_comb begin
        overflow_d = overflow_q;
        if (w_resp_edge && timeout_q)             overflow_d = 1'b1;
        else if (w_ctrl_wr && pwdata[CtrlClrOvfBit]) overflow_d = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        write_d    = write_q;
        timeout_d  = timeout_q;
        wait_cnt_d = wait_cnt_q;
        pready_d   = 1'b0;
        prdata_d   = '0;
        case (state_q)
            StIdle: begin
                if (psel && !penable) begin
                    kind_d     = w_kind;
                    write_d    = pwrite;
                    timeout_d  = 1'b0;
                    wait_cnt_d = '0;
                    if (w_kind == AccData && pwrite && w_full) begin
                        state_d = StWait;
                    end else begin
                        state_d  = StResp;
                        pready_d = 1'b1;
                        if (!pwrite && w_kind == AccStatus) begin
                            prdata_d = DataWidth'(status_word(16'(w_count), w_empty,
                                                              w_full, overflow_q));
                        end
                    end
                end
            end
            StWait: begin
                if (!w_full) begin
                    state_d  = StResp;
                    pready_d = 1'b1;
                end else if (wait_cnt_q == WaitW'(MaxWaitCycles - 1)) begin
                    state_d   = StResp;
                    pready_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            kind_q     <= AccNone;
            write_q    <= 1'b0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= '0;
            pready_q   <= 1'b0;
            prdata_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            write_q    <= write_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
            pready_q   <= pready_d;
            prdata_q   <= prdata_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef APB3_COMPLETER_FIFO_PSLVERR_EN
    logic pslverr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pslverr_q <= 1'b0;
        else        pslverr_q <= pready_d & (timeout_d | (kind_d == AccNone));
    end
    assign pslverr = pslverr_q;
`else
    assign pslverr = 1'b0;
`endif

    assign pready    = pready_q;
    assign prdata    = prdata_q;
    assign out_valid = ~w_empty;

    sync_fifo_showahead #(
        .Depth (Depth),
        .Width (DataWidth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .data_i  (pwdata),
        .pop_i   (out_ready),
        .flush_i (w_flush),
        .data_o  (out_data),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_apb3_completer_fifo.sv
`default_nettype none
// ============================================================================
// tb_apb3_completer_fifo : directed APB3 + stream scoreboard bench
// Revision : 1.0
// ============================================================================
module tb_apb3_completer_fifo;

`ifdef APB3_COMPLETER_FIFO_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    always #5 clk = ~clk;

    apb3_completer_fifo #(
        .AddressWidth  (20),
        .DataWidth     (32),
        .Depth         (8),
        .MaxWaitCycles (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  waits;
    } apb_exp_t;

    apb_exp_t    apb_q[$];
    logic [31:0] strm_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a transfer or a stream beat
    always @(negedge clk) begin
        apb_exp_t e;
        if (!rst_n) begin
            wait_cnt = 0;
        end else begin
            if (psel && penable) begin
                if (pready) begin
                    if (apb_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL apb_unexpected: got response prdata=0x%08h, want none", prdata);
                    end else begin
                        e = apb_q.pop_front();
                        check("apb_prdata", prdata, e.rdata);
                        check("apb_pslverr", 32'(pslverr), 32'(e.err));
                        check("apb_waits", 32'(wait_cnt), 32'(e.waits));
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (out_valid && out_ready) begin
                if (strm_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL strm_unexpected: got out_data=0x%08h, want no beat", out_data);
                end else begin
                    check("strm_data", out_data, strm_q.pop_front());
                end
            end
        end
    end

    task automatic apb(input logic [19:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_waits);
        apb_exp_t e;
        bit       got;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.waits = 8'(exp_waits);
        apb_q.push_back(e);
        @(posedge clk); #1;
        paddr = addr; pwrite = wr; pwdata = wdata; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (pready) got = 1'b1;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL apb_timeout addr=0x%05h: got pready=0 for 40 cycles, want 1", addr);
            void'(apb_q.pop_back());
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_data(input logic [31:0] d, input int waits);
        strm_q.push_back(d);
        apb(20'h0, 1'b1, d, 32'h0, 1'b0, waits);
    endtask

    task automatic rd_status(input logic [31:0] exp);
        apb(20'h4, 1'b0, 32'h0, exp, 1'b0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; paddr = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
        pwdata = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Empty status, then a single unstalled push
        rd_status(32'h0001_0000);
        wr_data(32'hA5A5_0001, 0);
        @(negedge clk);
        check("push1_out_valid", 32'(out_valid), 32'd1);
        check("push1_out_data", out_data, 32'hA5A5_0001);
        rd_status(32'h0000_0001);

        // Fill to 8, then a 9th write released by one pop during the 3rd wait cycle
        for (int i = 1; i <= 7; i++) wr_data(32'h1000_0000 + 32'(i), 0);
        rd_status(32'h0002_0008);
        strm_q.push_back(32'hDEAD_0009);
        fork
            apb(20'h0, 1'b1, 32'hDEAD_0009, 32'h0, 1'b0, 4);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
            end
        join
        rd_status(32'h0002_0008);

        // Write into a stuck-full FIFO: 15 waits, data dropped, overflow set
        apb(20'h0, 1'b1, 32'hBAD0_0000, 32'h0, ERR_EN, 15);
        rd_status(32'h0102_0008);

        // Unmapped and write-only/DATA reads
        apb(20'hC, 1'b0, 32'h0, 32'h0, ERR_EN, 0);
        apb(20'h10, 1'b1, 32'h1234_5678, 32'h0, ERR_EN, 0);
        apb(20'h8, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        apb(20'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        rd_status(32'h0102_0008);

        // Drain three words
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        rd_status(32'h0100_0005);

        // Flush on the same edge as a pop
        fork
            apb(20'h8, 1'b1, 32'h1, 32'h0, 1'b0, 0);
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
            end
        join
        strm_q.delete();
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        rd_status(32'h0101_0000);
        apb(20'h8, 1'b1, 32'h2, 32'h0, 1'b0, 0);
        rd_status(32'h0001_0000);

        // Reset while a full-FIFO write is waiting
        for (int i = 0; i < 8; i++) wr_data(32'h6000_0000 + 32'(i), 0);
        @(posedge clk); #1;
        paddr = 20'h0; pwrite = 1'b1; pwdata = 32'h7777_7777; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        strm_q.delete();
        #1;
        check("midrst_pready", 32'(pready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        wr_data(32'h0000_C0DE, 0);
        rd_status(32'h0000_0001);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("apb_q_drained", 32'(apb_q.size()), 32'd0);
        check("strm_q_drained", 32'(strm_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb3_completer_fifo.md
# apb3_completer_fifo

APB3 completer that turns bus writes into a stream: words written to its DATA register are pushed into an internal FIFO and drained through a valid/ready output port. It sits directly downstream of `apb3_requester_synth` on the `renode_apb3_if` bus, as an alternative completer to `apb3_completer_mem`. When the FIFO is full, the block applies APB3 back-pressure with PREADY wait states. Status and control registers give the requester visibility of the FIFO and a flush control.

## Interface
- `AddressWidth`, 20, width of `paddr`.
- `DataWidth`, 32, width of `pwdata`/`prdata`/`out_data`; must be ≥ 32.
- `Depth`, 8, FIFO entries; power of two, ≥ 2.
- `MaxWaitCycles`, 15, maximum wait states inserted on a full-FIFO write before the transfer is aborted.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `paddr` in AddressWidth: byte address.
- `pwrite` in 1: 1 = write.
- `psel` in 1: completer select.
- `penable` in 1: access phase.
- `pwdata` in DataWidth: write data.
- `prdata` out DataWidth: read data; valid only while `pready` = 1.
- `pready` out 1: transfer completes this cycle.
- `pslverr` out 1: error response; valid only while `pready` = 1.
- `out_valid` out 1: FIFO head is available.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out DataWidth: FIFO head (show-ahead).

## Operation
- **Register map** (`paddr` offset from 0):
  - 0x0 DATA: a write pushes `pwdata`; a read returns 0.
  - 0x4 STATUS (read-only):
    - [15:0] count, zero-extended.
    - [16] empty.
    - [17] full.
    - [24] overflow (sticky).
  - 0x8 CTRL (write-only; reads return 0):
    - bit0 = 1 flushes the FIFO.
    - bit1 = 1 clears overflow.
  - Any other offset is unmapped: reads return 0, writes are ignored, and the access is flagged as an error.
- **FSM states:**
  - IDLE: waiting for a transfer. In the setup phase (`psel` & !`penable`), decode the address. A DATA write while full goes to WAIT; any other access goes to RESP.
  - WAIT: increment the wait counter each cycle.
    - If not full, go to RESP with a normal response.
    - If the counter reaches `MaxWaitCycles`, go to RESP as an error (timeout).
  - RESP: `pready` = 1 for exactly one cycle, then return to IDLE.
- **Side effects** happen only at the RESP edge (`psel` & `penable` & `pready`):
  - push on a DATA write;
  - flush or overflow clear on a CTRL write;
  - on timeout, no push and overflow is set.
- **Stream side:** `out_valid` = !empty. A pop occurs when `out_valid` & `out_ready`.
- **Simultaneous events:**
  - A push and a pop on the same edge leave count unchanged.
  - A flush on the same edge as a pop: the flush wins and count becomes 0.
  - A pop on the edge where WAIT evaluates full: the space becomes visible the next cycle and the write completes one cycle later. Only the APB side pushes, so that space cannot be lost.
- **Reset mid-transfer:** `rst_n` low clears the FSM, FIFO, counters and overflow immediately. Any in-flight APB transfer is abandoned, and the requester must restart it.

## Timing
- Reset values: `prdata` = 0, `pready` = 0, `pslverr` = 0, `out_valid` = 0, `out_data` = 0. Storage is cleared on reset.
- `pready`, `prdata` and `pslverr` are registered.
- Non-stalled access: setup cycle plus one access cycle with `pready` = 1, i.e. zero wait states.
- Full-FIFO write: N wait states, where N = cycles until space appears, capped at `MaxWaitCycles`.
- `out_data` reflects a new head the cycle after the push edge. There is no extra stream latency.
- STATUS is sampled at the edge that enters RESP.

## Configuration
- `APB3_COMPLETER_FIFO_PSLVERR_EN`:
  - Defined: `pslverr` = 1 in the RESP cycle for unmapped accesses and for timeouts.
  - Undefined: `pslverr` is tied to 0. Timeouts still drop the data and set overflow.

## Structure
- Package `apb3_completer_fifo_pkg` holds:
  - register offsets `DataOffset`, `StatusOffset`, `CtrlOffset`;
  - STATUS bit positions;
  - CTRL bit positions;
  - the FSM state enum `fifo_state_e`.
- One sub-module, `sync_fifo_showahead`: parameterised Depth/Width, with push, pop, flush, count, full and empty.

## Test plan
1. Reset, then read STATUS → 0x0001_0000 (empty, count 0); `out_valid` = 0.
2. Write 0xA5A5_0001 to DATA with `out_ready` = 0 → zero wait states; `out_valid` = 1, `out_data` = 0xA5A5_0001; STATUS count = 1.
3. With `out_ready` = 0, fill 8 entries, then write a 9th; assert `out_ready` after 3 wait cycles → `pready` rises 1 cycle later. The 9th word is stored and the first word is popped.
4. Full FIFO, `out_ready` held 0, DATA write → 15 wait states, then `pready` = 1 with `pslverr` = 1 (macro on) or 0 (macro off). STATUS bit24 = 1 and count stays 8.
5. Write 0x1 to CTRL with 5 entries queued, with `out_ready` = 1 on the same edge → count = 0 and `out_valid` = 0. Write 0x2 to CTRL → overflow cleared.
6. Pull `rst_n` low during a WAIT state → `pready` = 0 and FIFO empty immediately. After release, a DATA write completes with zero wait states.
